// File: rtl/scan_chain_controller.sv
// Scan chain sequencer: accepts a command, optionally pulses a parallel capture,
// shifts up to MAX_LEN bits through the chain and returns the collected bits.
module scan_chain_controller #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_capture,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_din,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_dout,
  output logic               scan_enable,
  output logic               scan_in,
  input  logic               scan_out,
  output logic               capture_enable,
  output logic               func_hold,
  output logic               busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] SHIFT   = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_C     = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] ZERO_C    = {LEN_W{1'b0}};

  logic [1:0]         state_r;
  logic [1:0]         state_s;
  logic [MAX_LEN-1:0] din_r;
  logic [MAX_LEN-1:0] dout_r;
  logic [LEN_W-1:0]   cnt_r;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   len_clamp_s;
  logic [MAX_LEN-1:0] din_shift_s;
  logic [MAX_LEN-1:0] out_bit_s;
  logic               accept_s;

  assign len_clamp_s = (cmd_len > MAX_LEN_C) ? MAX_LEN_C : cmd_len;
  assign accept_s    = (state_r == IDLE) && cmd_valid;
  assign din_shift_s = din_r >> cnt_r;
  assign out_bit_s   = {{(MAX_LEN-1){1'b0}}, scan_out};

  // Next-state selection for the capture/shift/response sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_capture) begin
            state_s = CAPTURE;
          end else if (len_clamp_s != ZERO_C) begin
            state_s = SHIFT;
          end else begin
            state_s = RESP;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CAPTURE: begin
        if (len_r != ZERO_C) begin
          state_s = SHIFT;
        end else begin
          state_s = RESP;
        end
      end
      SHIFT: begin
        if (cnt_r == (len_r - ONE_C)) begin
          state_s = RESP;
        end else begin
          state_s = SHIFT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, command latch and response accumulation; each shift stores the
  // chain tail value seen before that shift edge into bit cnt_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      din_r   <= {MAX_LEN{1'b0}};
      dout_r  <= {MAX_LEN{1'b0}};
      cnt_r   <= ZERO_C;
      len_r   <= ZERO_C;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        din_r  <= cmd_din;
        dout_r <= {MAX_LEN{1'b0}};
        cnt_r  <= ZERO_C;
        len_r  <= len_clamp_s;
      end else if (state_r == SHIFT) begin
        dout_r <= dout_r | (out_bit_s << cnt_r);
        cnt_r  <= cnt_r + ONE_C;
      end else begin
        cnt_r  <= cnt_r;
      end
    end
  end

  // Chain controls decode straight from state so the chain acts in the same cycle.
  assign cmd_ready      = (state_r == IDLE);
  assign busy           = (state_r != IDLE);
  assign func_hold      = busy;
  assign capture_enable = (state_r == CAPTURE);
  assign scan_enable    = (state_r == SHIFT);
  assign scan_in        = scan_enable ? din_shift_s[0] : 1'b0;
  assign rsp_valid      = (state_r == RESP);
  assign rsp_dout       = rsp_valid ? dout_r : {MAX_LEN{1'b0}};

endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench for scan_chain_controller: behavioural chain, queue-based response model,
// per-cycle output comparison and directed scenarios with literal expectations.
module tb_scan_chain_controller;

  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_capture = 1'b0;
  logic [6:0]  cmd_len = 7'd0;
  logic [63:0] cmd_din = 64'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_dout;
  logic        scan_enable;
  logic        scan_in;
  logic        scan_out;
  logic        capture_enable;
  logic        func_hold;
  logic        busy;

  int errors = 0;
  int checks = 0;

  scan_chain_controller #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_capture(cmd_capture), .cmd_len(cmd_len), .cmd_din(cmd_din),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dout(rsp_dout),
    .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
    .capture_enable(capture_enable), .func_hold(func_hold), .busy(busy)
  );

  always #5 clk = ~clk;

  // Chain of chain_len stages: scan_in enters bit 0, scan_out is the top bit.
  int          chain_len = 8;
  logic [63:0] chain = 64'd0;
  logic [63:0] chain_din = 64'd0;
  logic [63:0] preload_val = 64'd0;
  logic        preload_req = 1'b0;
  int          shift_total = 0;
  int          cap_total = 0;
  int          accept_total = 0;

  function automatic logic [63:0] len_mask(input int n);
    return (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] rev(input logic [63:0] v, input int n);
    logic [63:0] r = 64'd0;
    for (int i = 0; i < n; i++) r[n-1-i] = v[i];
    return r;
  endfunction

  assign scan_out = chain[chain_len-1];

  always @(posedge clk) begin
    if (preload_req) chain <= preload_val & len_mask(chain_len);
    else if (capture_enable) chain <= chain_din & len_mask(chain_len);
    else if (scan_enable) chain <= ((chain << 1) | {63'd0, scan_in}) & len_mask(chain_len);
    if (scan_enable) shift_total <= shift_total + 1;
    if (capture_enable) cap_total <= cap_total + 1;
    if (cmd_valid && cmd_ready && !rst) accept_total <= accept_total + 1;
  end

  // Model: the chain as a FIFO of bits (tail first); each shift pops one bit
  // out and pushes one command bit in. Returns response or final chain image.
  function automatic logic [63:0] predict(input logic [63:0] snap, input int clen,
                                          input int n, input logic [63:0] din,
                                          input bit want_chain);
    logic q[$];
    logic [63:0] r = 64'd0;
    for (int j = 0; j < clen; j++) q.push_back(snap[clen-1-j]);
    for (int k = 0; k < n; k++) begin
      r[k] = q.pop_front();
      q.push_back(din[k]);
    end
    if (want_chain) begin
      r = 64'd0;
      for (int j = 0; j < clen; j++) r[clen-1-j] = q[j];
    end
    return r;
  endfunction

  logic        m_init = 1'b0;
  logic        m_active = 1'b0;
  logic        m_cap = 1'b0;
  int          m_t = 0;
  int          m_len = 0;
  logic [63:0] m_din = 64'd0;
  logic [63:0] m_exp = 64'd0;
  logic [63:0] m_exp_chain = 64'd0;

  // m_t counts cycles since the accept edge; phases follow from m_cap and m_len.
  always @(posedge clk) begin
    if (rst) begin
      m_init   <= 1'b1;
      m_active <= 1'b0;
      m_t      <= 0;
    end else if (!m_active) begin
      if (cmd_valid) begin
        m_active    <= 1'b1;
        m_t         <= 1;
        m_cap       <= cmd_capture;
        m_len       <= (int'(cmd_len) > MAX_LEN) ? MAX_LEN : int'(cmd_len);
        m_din       <= cmd_din;
        m_exp       <= predict(cmd_capture ? (chain_din & len_mask(chain_len)) : chain, chain_len,
                               (int'(cmd_len) > MAX_LEN) ? MAX_LEN : int'(cmd_len), cmd_din, 1'b0);
        m_exp_chain <= predict(cmd_capture ? (chain_din & len_mask(chain_len)) : chain, chain_len,
                               (int'(cmd_len) > MAX_LEN) ? MAX_LEN : int'(cmd_len), cmd_din, 1'b1);
      end
    end else if ((m_t >= m_len + int'(m_cap) + 1) && rsp_ready) begin
      m_active <= 1'b0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [63:0] v);
    @(posedge clk); #1;
    preload_val = v;
    preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
  endtask

  task automatic do_cmd(input logic cap, input logic [6:0] len, input logic [63:0] din,
                        input int stall, output logic [63:0] dout, output int lat);
    int n;
    logic [63:0] first;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_capture = cap; cmd_len = len; cmd_din = din; rsp_ready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
    first = rsp_dout;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_dout", rsp_dout, first);
      chk("bp_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      chk("bp_scan", {62'd0, scan_enable, capture_enable}, 64'd0);
    end
    dout = rsp_dout;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("idle_after_rsp", {63'd0, cmd_ready}, 64'd1);
  endtask

  initial begin
    fork
      // Per-cycle comparison of every output against the model.
      begin
        forever begin
          @(negedge clk);
          if (m_init) begin
            automatic int  base   = int'(m_cap);
            automatic bit  e_cap  = m_active && m_cap && (m_t == 1);
            automatic bit  e_sh   = m_active && (m_t >= base + 1) && (m_t <= base + m_len);
            automatic bit  e_rv   = m_active && (m_t >= base + m_len + 1);
            automatic bit  e_si   = e_sh ? m_din[m_t-base-1] : 1'b0;
            chk("cyc_cmd_ready", {63'd0, cmd_ready}, {63'd0, !m_active});
            chk("cyc_busy", {62'd0, busy, func_hold}, {62'd0, m_active, m_active});
            chk("cyc_capture_enable", {63'd0, capture_enable}, {63'd0, e_cap});
            chk("cyc_scan_enable", {63'd0, scan_enable}, {63'd0, e_sh});
            chk("cyc_scan_in", {63'd0, scan_in}, {63'd0, e_si});
            chk("cyc_rsp_valid", {63'd0, rsp_valid}, {63'd0, e_rv});
            chk("cyc_rsp_dout", rsp_dout, e_rv ? m_exp : 64'd0);
          end
        end
      end
      begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
      end
      begin
        logic [63:0] dout;
        logic [63:0] pat_p;
        logic [63:0] pat_r;
        int lat;
        int s0;
        int c0;
        int a0;
        bit saw_rsp;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_scan", {61'd0, scan_enable, capture_enable, scan_in}, 64'd0);
        chk("rst_busy", {62'd0, busy, func_hold}, 64'd0);
        chk("rst_rsp_dout", rsp_dout, 64'd0);
        rst = 1'b0;

        // Plain 8-bit shift through a chain preloaded with A5.
        chain_len = 8; chain_din = 64'd0;
        preload(64'hA5);
        s0 = shift_total;
        do_cmd(1'b0, 7'd8, 64'h3C, 0, dout, lat);
        chk("plain_shifts", 64'(shift_total - s0), 64'd8);
        chk("plain_dout", dout, 64'hA5);
        chk("plain_model", m_exp, 64'hA5);
        chk("plain_chain", chain, 64'h3C);
        chk("plain_chain_model", m_exp_chain, 64'h3C);
        chk("plain_latency", 64'(lat), 64'd9);

        // Capture of 96 then shift: bits come out MSB first.
        chain_din = 64'h96;
        preload(64'h00);
        s0 = shift_total; c0 = cap_total;
        do_cmd(1'b1, 7'd8, 64'h0, 0, dout, lat);
        chk("cap_pulses", 64'(cap_total - c0), 64'd1);
        chk("cap_shifts", 64'(shift_total - s0), 64'd8);
        chk("cap_dout", dout, 64'h69);
        chk("cap_model", m_exp, 64'h69);
        chk("cap_latency", 64'(lat), 64'd10);

        // Zero-length command without capture.
        s0 = shift_total;
        do_cmd(1'b0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, dout, lat);
        chk("len0_shifts", 64'(shift_total - s0), 64'd0);
        chk("len0_latency", 64'(lat), 64'd1);
        chk("len0_dout", dout, 64'd0);

        // Full 64-bit round trip.
        chain_len = 64;
        pat_p = {$urandom, $urandom};
        pat_r = {$urandom, $urandom};
        preload(pat_p);
        s0 = shift_total;
        do_cmd(1'b0, 7'd64, pat_r, 0, dout, lat);
        chk("full_shifts", 64'(shift_total - s0), 64'd64);
        chk("full_dout", dout, rev(pat_p, 64));
        chk("full_chain", chain, rev(pat_r, 64));
        chk("full_latency", 64'(lat), 64'd65);

        // Oversized length clamps to 64; chain now returns the previous pattern.
        s0 = shift_total;
        do_cmd(1'b0, 7'd100, 64'h0123_4567_89AB_CDEF, 0, dout, lat);
        chk("clamp_shifts", 64'(shift_total - s0), 64'd64);
        chk("clamp_dout", dout, pat_r);
        chk("clamp_latency", 64'(lat), 64'd65);

        // Response backpressure for five cycles.
        chain_len = 8;
        preload(64'h5A);
        do_cmd(1'b0, 7'd4, 64'h9, 5, dout, lat);
        chk("bp_final_dout", dout, 64'hA);
        chk("bp_latency", 64'(lat), 64'd5);

        // Back-to-back with cmd_valid held: second accept waits for the handshake.
        @(posedge clk); #1;
        a0 = accept_total;
        cmd_valid = 1'b1; cmd_capture = 1'b0; cmd_len = 7'd4; cmd_din = 64'h6; rsp_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("b2b_one_accept", 64'(accept_total - a0), 64'd1);
        chk("b2b_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("b2b_idle", {63'd0, cmd_ready}, 64'd1);
        chk("b2b_still_one", 64'(accept_total - a0), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("b2b_two_accepts", 64'(accept_total - a0), 64'd2);
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        a0 = 0;
        while (!rsp_valid && a0 < 50) begin
          @(posedge clk); #1; a0++;
        end
        chk("b2b_second_rsp", {63'd0, rsp_valid}, 64'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset during shift cycle 3 of 8 aborts without a response.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_capture = 1'b0; cmd_len = 7'd8; cmd_din = 64'hF0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_mid_shift", {63'd0, scan_enable}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle", {63'd0, cmd_ready}, 64'd1);
        chk("abort_scan", {62'd0, scan_enable, capture_enable}, 64'd0);
        chk("abort_rsp_dout", rsp_dout, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        saw_rsp = 1'b0;
        repeat (12) begin
          @(posedge clk); #1;
          if (rsp_valid || scan_enable) saw_rsp = 1'b1;
        end
        chk("abort_no_rsp", {63'd0, saw_rsp}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    join
  end

endmodule
